// File: rtl/ahb_bridge_arbiter.sv
// Round-robin AHB arbiter that shares the bridge slave port among NUM_MASTERS masters.
// Optional ARB_HLOCK_EN: a locked owner keeps the bus until it drops Hlock.
module ahb_bridge_arbiter #(
    parameter int WIDTH       = 32,
    parameter int NUM_MASTERS = 4,
    parameter int MW          = 2
) (
    input  logic                         Hclk,
    input  logic                         Hreset,
    input  logic [NUM_MASTERS-1:0]       Hbusreq,
    input  logic [NUM_MASTERS-1:0]       Hlock,
    input  logic [2*NUM_MASTERS-1:0]     Htrans_m,
    input  logic [WIDTH*NUM_MASTERS-1:0] Haddr_m,
    input  logic [NUM_MASTERS-1:0]       Hwrite_m,
    input  logic [3*NUM_MASTERS-1:0]     Hsize_m,
    input  logic [WIDTH*NUM_MASTERS-1:0] Hwdata_m,
    input  logic                         Hreadyout_s,
    input  logic [1:0]                   Hresp_s,
    input  logic [WIDTH-1:0]             Hrdata_s,
    output logic [NUM_MASTERS-1:0]       Hgrant,
    output logic [MW-1:0]                Hmaster,
    output logic [1:0]                   Htrans,
    output logic [WIDTH-1:0]             Haddr,
    output logic                         Hwrite,
    output logic [2:0]                   Hsize,
    output logic [WIDTH-1:0]             Hwdata,
    output logic                         Hreadyin,
    output logic                         Hready,
    output logic [1:0]                   Hresp,
    output logic [WIDTH-1:0]             Hrdata
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    logic [MW-1:0]          r_master;
    logic [MW-1:0]          r_master_d;
    logic [MW-1:0]          r_rr_ptr;
    logic [NUM_MASTERS-1:0] r_grant;

    logic [1:0]             w_own_trans;
    logic                   w_ap_base;
    logic                   w_ap;
    logic [MW-1:0]          w_win;
    logic                   w_found;
    logic [MW:0]            w_idx;

    assign w_own_trans = Htrans_m[2*r_master +: 2];
    assign w_ap_base   = Hreadyout_s &&
                         (w_own_trans == TR_IDLE || w_own_trans == TR_NONSEQ);

`ifdef ARB_HLOCK_EN
    // Lock left over from before reset is not honoured until the first AP.
    logic r_lock_ign;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_lock_ign <= 1'b1;
        end else if (w_ap_base) begin
            r_lock_ign <= 1'b0;
        end
    end

    assign w_ap = w_ap_base && (r_lock_ign || !Hlock[r_master]);
`else
    logic w_unused_lock;
    assign w_unused_lock = ^Hlock;
    assign w_ap          = w_ap_base;
`endif

    // Scan rr_ptr+1 .. rr_ptr+N; the last slot is the current owner.
    always_comb begin
        w_win   = r_rr_ptr;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (MW+1)'(k);
            if (w_idx >= (MW+1)'(NUM_MASTERS)) begin
                w_idx = w_idx - (MW+1)'(NUM_MASTERS);
            end
            if (!w_found && Hbusreq[w_idx[MW-1:0]]) begin
                w_win   = w_idx[MW-1:0];
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_master   <= '0;
            r_master_d <= '0;
            r_rr_ptr   <= '0;
            r_grant    <= NUM_MASTERS'(1);
        end else begin
            if (Hreadyout_s) begin
                r_master_d <= r_master;
            end
            if (w_ap && w_found) begin
                r_master <= w_win;
                r_rr_ptr <= w_win;
                r_grant  <= NUM_MASTERS'(1) << w_win;
            end
        end
    end

    assign Hgrant   = r_grant;
    assign Hmaster  = r_master;
    assign Htrans   = Hreset ? TR_IDLE : w_own_trans;
    assign Haddr    = Haddr_m[WIDTH*r_master +: WIDTH];
    assign Hwrite   = Hwrite_m[r_master];
    assign Hsize    = Hsize_m[3*r_master +: 3];
    assign Hwdata   = Hwdata_m[WIDTH*r_master_d +: WIDTH];
    assign Hreadyin = Hreadyout_s;
    assign Hready   = Hreadyout_s;
    assign Hresp    = Hresp_s;
    assign Hrdata   = Hrdata_s;

endmodule

// File: doc/ahb_bridge_arbiter.md
Name: ahb_bridge_arbiter

Overview:
Round-robin AHB bus arbiter that lets NUM_MASTERS AHB masters share the single AHB-slave port of the AHB-to-APB bridge (rtl_top).
- Registers ownership and muxes the owner's address/control onto the bridge.
- Tracks the data-phase owner so Hwdata is taken from the correct master.
- Broadcasts the bridge's Hreadyout/Hresp/Hrdata back to all masters.
- Sits between the master-side interconnect and rtl_top, one instance per bridge.

Parameters:
WIDTH, 32, address/data width; matches `WIDTH of the bridge.
NUM_MASTERS, 4, number of requesting masters; 2..8.
MW, 2, width of master index; must equal clog2(NUM_MASTERS).

Ports:
Hclk  input  1  clock
Hreset  input  1  synchronous active-high reset
Hbusreq  input  NUM_MASTERS  bus request, one bit per master
Hlock  input  NUM_MASTERS  locked-transfer request; used only with ARB_HLOCK_EN
Htrans_m  input  2*NUM_MASTERS  packed Htrans; master i at [2i+1:2i]
Haddr_m  input  WIDTH*NUM_MASTERS  packed addresses
Hwrite_m  input  NUM_MASTERS  packed Hwrite
Hsize_m  input  3*NUM_MASTERS  packed Hsize
Hwdata_m  input  WIDTH*NUM_MASTERS  packed write data
Hreadyout_s  input  1  ready from bridge
Hresp_s  input  2  response from bridge
Hrdata_s  input  WIDTH  read data from bridge
Hgrant  output  NUM_MASTERS  one-hot grant, registered
Hmaster  output  MW  address-phase owner index, registered
Htrans  output  2  to bridge
Haddr  output  WIDTH  to bridge
Hwrite  output  1  to bridge
Hsize  output  3  to bridge
Hwdata  output  WIDTH  to bridge
Hreadyin  output  1  to bridge; equals Hreadyout_s
Hready  output  1  broadcast to all masters; equals Hreadyout_s
Hresp  output  2  broadcast; equals Hresp_s
Hrdata  output  WIDTH  broadcast; equals Hrdata_s

Behaviour:
- Clocking and reset: one clock Hclk; reset Hreset is synchronous, active-high.
- Reset values: Hmaster=0, Hgrant=1 (park on master 0), data-phase owner Hmaster_d=0, rr_ptr=0.
- While Hreset=1, Htrans is forced to 2'b00 (IDLE). All other outputs follow the muxes.
- Address mux (combinational): Htrans/Haddr/Hwrite/Hsize are taken from master Hmaster.
- Data mux (combinational): Hwdata is taken from master Hmaster_d.
- Hmaster_d <= Hmaster on every edge where Hreadyout_s=1. It holds while Hreadyout_s=0.
- Arbitration point (AP): Hreadyout_s=1 AND owner's Htrans is IDLE (00) or NONSEQ (10).
  - SEQ (11) and BUSY (01) are never APs, so a burst is never split.
- At an AP with any Hbusreq set:
  - Winner = first requester scanning rr_ptr+1, rr_ptr+2, … modulo NUM_MASTERS, wrapping.
  - The current owner is eligible only after all others have been scanned.
  - Registers update: Hmaster <= winner, Hgrant <= onehot(winner), rr_ptr <= winner.
- At an AP with no requests: ownership is unchanged (park on last owner).
- Grant latency: request seen at AP edge N → Hgrant/Hmaster change at edge N; the new owner drives the address phase from that cycle.
- Outside an AP: Hgrant/Hmaster hold, even if the owner drops Hbusreq.
- Hreadyout_s=0: nothing changes except muxing. Wait states extend the handover.
- Handover data phase: the old owner's pending data phase completes with Hmaster_d = old owner, so the old owner's Hwdata is used.
- Hresp_s ERROR/RETRY/SPLIT is passed through unmodified. The arbiter does not re-arbitrate on it; masters must drive IDLE, which creates an AP.
- Single master requesting continuously: keeps the grant indefinitely.
- Reset mid-burst: immediate return to reset values on the next edge; the in-flight beat is abandoned.

Optional Feature:
ARB_HLOCK_EN
- Defined: an AP additionally requires Hlock[Hmaster]=0. A locked owner keeps the grant across NONSEQ/IDLE until it deasserts Hlock.
- Defined: lock is sampled the same cycle as Htrans. Any lock held on the cycle after reset deassertion is ignored until the first AP.
- Undefined: the Hlock port exists but is ignored; AP is defined as above.

Test Plan:
- Reset: Hreset=1 for 2 cycles with all Hbusreq=4'b1111 → Hgrant=4'b0001, Hmaster=0, Htrans=00. After release, first AP grants master 1.
- Round-robin: all four request, each issues single NONSEQ writes, Hreadyout_s=1 → grant order 1,2,3,0,1. Haddr alternates between each master's address; Hwdata one cycle later matches the previous owner.
- Burst protection: master 2 owns and issues INCR4 (NONSEQ,SEQ,SEQ,SEQ) while master 3 requests → Hmaster stays 2 for all 4 beats, switches to 3 on the edge after the last SEQ when master 2 goes IDLE.
- Wait states: Hreadyout_s=0 for 3 cycles during a handover from 0 to 1 → Hmaster_d stays 0, Hwdata = Hwdata_m of master 0 until Hreadyout_s=1.
- Park: only master 2 requests, then drops Hbusreq → Hgrant stays 4'b0100; Htrans IDLE passes through.
- ARB_HLOCK_EN: master 1 holds Hlock=1 across two NONSEQ transfers with master 0 requesting → no grant change until Hlock=0. Without the macro, master 0 is granted at the first NONSEQ AP.
